fire_dispatch: RTL and testbench

Fan-out stage directly downstream of `fire_fifo`. Pops one fired-neuron tag at a time from the FIFO's show-ahead head and looks up that neuron's row descriptor (edge start address, edge count) in a pointer memory. It then walks the row in an edge memory and emits one synaptic event (destination neuron, weight) per edge to the synaptic accumulator, under valid/ready backpressure.

---
 rtl/fire_pkg.sv | 18 +
 rtl/fire_dispatch_if.sv | 41 ++++
 rtl/fire_dispatch_edge_walker.sv | 38 +++
 rtl/fire_dispatch.sv | 142 ++++++++++++++
 tb/tb_fire_dispatch.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fire_pkg.sv
// Shared definitions for the fire_fifo / fire_dispatch spike path: default widths and the
// dispatch FSM state encoding.
package fire_pkg;

  localparam int unsigned DEF_TAG_W    = 4;
  localparam int unsigned DEF_EDGE_AW  = 6;
  localparam int unsigned DEF_CNT_W    = 4;
  localparam int unsigned DEF_WEIGHT_W = 8;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPtrWait  = 3'd1,
    StEdgeRd   = 3'd2,
    StEdgeWait = 3'd3,
    StOut      = 3'd4
  } dispatch_state_e;

endpackage

// File: rtl/fire_dispatch_if.sv
// Bus bundle around fire_dispatch: FIFO pop side, pointer/edge memory read ports and the
// synaptic event valid/ready channel. master = dispatcher, slave = its environment.
interface fire_dispatch_if
  import fire_pkg::*;
#(
    parameter int unsigned TAG_W    = DEF_TAG_W,
    parameter int unsigned EDGE_AW  = DEF_EDGE_AW,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned WEIGHT_W = DEF_WEIGHT_W
);

    logic                fifo_empty;
    logic [TAG_W-1:0]    fifo_tag;
    logic                fifo_deq;

    logic                ptr_rd;
    logic [TAG_W-1:0]    ptr_addr;
    logic [EDGE_AW-1:0]  ptr_start;
    logic [CNT_W-1:0]    ptr_count;

    logic                edge_rd;
    logic [EDGE_AW-1:0]  edge_addr;
    logic [TAG_W-1:0]    edge_dst;
    logic [WEIGHT_W-1:0] edge_weight;

    logic                syn_valid;
    logic                syn_ready;
    logic [TAG_W-1:0]    syn_dst;
    logic [WEIGHT_W-1:0] syn_weight;

    modport master (
        input  fifo_empty, fifo_tag, ptr_start, ptr_count, edge_dst, edge_weight, syn_ready,
        output fifo_deq, ptr_rd, ptr_addr, edge_rd, edge_addr, syn_valid, syn_dst, syn_weight
    );

    modport slave (
        output fifo_empty, fifo_tag, ptr_start, ptr_count, edge_dst, edge_weight, syn_ready,
        input  fifo_deq, ptr_rd, ptr_addr, edge_rd, edge_addr, syn_valid, syn_dst, syn_weight
    );

endinterface

// File: rtl/fire_dispatch_edge_walker.sv
// Row walker for fire_dispatch: edge address counter (wraps mod 2^EDGE_AW) and remaining-edge
// counter, loaded from the row descriptor and stepped once per consumed edge.
module edge_walker
  import fire_pkg::*;
#(
    parameter int unsigned EDGE_AW = DEF_EDGE_AW,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               asyn_reset,
    input  logic               load,
    input  logic               step,
    input  logic [EDGE_AW-1:0] load_start,
    input  logic [CNT_W-1:0]   load_count,
    output logic [EDGE_AW-1:0] addr,
    output logic               last
);

    logic [EDGE_AW-1:0] addr_q;
    logic [CNT_W-1:0]   rem_q;

    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else if (load) begin
            addr_q <= load_start;
            rem_q  <= load_count;
        end else if (step) begin
            addr_q <= addr_q + EDGE_AW'(1);
            rem_q  <= rem_q - CNT_W'(1);
        end
    end

    assign addr = addr_q;
    assign last = (rem_q == CNT_W'(1));

endmodule

// File: rtl/fire_dispatch.sv
// Fan-out stage after fire_fifo: pops a fired tag, reads its row descriptor, then walks the row
// emitting one (dst, weight) event per edge. Define FIRE_DISPATCH_SKIP_ZERO_EN to drop w=0 edges.
module fire_dispatch
  import fire_pkg::*;
#(
    parameter int unsigned TAG_W    = DEF_TAG_W,
    parameter int unsigned EDGE_AW  = DEF_EDGE_AW,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned WEIGHT_W = DEF_WEIGHT_W
) (
    input  logic            clk,
    input  logic            asyn_reset,
    fire_dispatch_if.master bus,
    output logic            busy,
    output logic            spike_done
);

    dispatch_state_e     state_q, state_d;
    logic [TAG_W-1:0]    tag_q;
    logic [TAG_W-1:0]    dst_q;
    logic [WEIGHT_W-1:0] weight_q;
    logic                done_q, done_d;

    logic                pop;
    logic                issue_rd;
    logic                walk_load;
    logic                walk_step;
    logic                walk_last;
    logic                capture;
    logic [EDGE_AW-1:0]  walk_addr;

    edge_walker #(
        .EDGE_AW (EDGE_AW),
        .CNT_W   (CNT_W)
    ) u_walker (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .load       (walk_load),
        .step       (walk_step),
        .load_start (bus.ptr_start),
        .load_count (bus.ptr_count),
        .addr       (walk_addr),
        .last       (walk_last)
    );

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        issue_rd  = 1'b0;
        walk_load = 1'b0;
        walk_step = 1'b0;
        capture   = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Gated by reset so the pop strobe stays low while reset is held.
                if (!bus.fifo_empty && asyn_reset) begin
                    pop     = 1'b1;
                    state_d = StPtrWait;
                end
            end
            StPtrWait: begin
                walk_load = 1'b1;
                if (bus.ptr_count == '0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StEdgeRd;
                end
            end
            StEdgeRd: begin
                issue_rd = 1'b1;
                state_d  = StEdgeWait;
            end
            StEdgeWait: begin
`ifdef FIRE_DISPATCH_SKIP_ZERO_EN
                if (bus.edge_weight == '0) begin
                    walk_step = 1'b1;
                    if (walk_last) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StEdgeRd;
                    end
                end else begin
                    capture = 1'b1;
                    state_d = StOut;
                end
`else
                capture = 1'b1;
                state_d = StOut;
`endif
            end
            StOut: begin
                if (bus.syn_ready) begin
                    walk_step = 1'b1;
                    if (walk_last) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StEdgeRd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            state_q  <= StIdle;
            tag_q    <= '0;
            dst_q    <= '0;
            weight_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (pop) begin
                tag_q <= bus.fifo_tag;
            end
            if (capture) begin
                dst_q    <= bus.edge_dst;
                weight_q <= bus.edge_weight;
            end
        end
    end

    assign bus.fifo_deq   = pop;
    assign bus.ptr_rd     = pop;
    // The active row's tag stays on the pointer address bus between lookups.
    assign bus.ptr_addr   = pop ? bus.fifo_tag : tag_q;
    assign bus.edge_rd    = issue_rd;
    assign bus.edge_addr  = walk_addr;
    assign bus.syn_valid  = (state_q == StOut);
    assign bus.syn_dst    = dst_q;
    assign bus.syn_weight = weight_q;

    assign busy       = (state_q != StIdle);
    assign spike_done = done_q;

endmodule

// File: tb/tb_fire_dispatch.sv
// Directed bench for fire_dispatch with behavioural FIFO and memory models and an event
// scoreboard; timing is checked from logged cycle numbers.
module tb_fire_dispatch;

    localparam int unsigned TAG_W    = 4;
    localparam int unsigned EDGE_AW  = 6;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned WEIGHT_W = 8;

    typedef struct packed {
        logic [TAG_W-1:0]    dst;
        logic [WEIGHT_W-1:0] w;
    } ev_t;

    logic clk;
    logic asyn_reset;
    logic busy;
    logic spike_done;

    fire_dispatch_if #(
        .TAG_W    (TAG_W),
        .EDGE_AW  (EDGE_AW),
        .CNT_W    (CNT_W),
        .WEIGHT_W (WEIGHT_W)
    ) bus ();

    fire_dispatch #(
        .TAG_W    (TAG_W),
        .EDGE_AW  (EDGE_AW),
        .CNT_W    (CNT_W),
        .WEIGHT_W (WEIGHT_W)
    ) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .bus        (bus),
        .busy       (busy),
        .spike_done (spike_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [TAG_W-1:0]    fifo_q [$];
    ev_t                 exp_q [$];
    int                  deq_cyc [$];
    logic [TAG_W-1:0]    deq_tag [$];
    int                  ev_cyc [$];
    int                  done_cyc [$];
    logic [EDGE_AW-1:0]  eaddr [$];

    logic [EDGE_AW-1:0]  ptr_start_mem [16];
    logic [CNT_W-1:0]    ptr_count_mem [16];
    logic [TAG_W-1:0]    edge_dst_mem  [64];
    logic [WEIGHT_W-1:0] edge_w_mem    [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Show-ahead FIFO model
    always @(posedge clk) begin
        if (bus.fifo_deq === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
        bus.fifo_empty <= (fifo_q.size() == 0);
        bus.fifo_tag   <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end

    // Memories with one cycle read latency
    always @(posedge clk) begin
        if (bus.ptr_rd === 1'b1) begin
            bus.ptr_start <= ptr_start_mem[bus.ptr_addr];
            bus.ptr_count <= ptr_count_mem[bus.ptr_addr];
        end
        if (bus.edge_rd === 1'b1) begin
            bus.edge_dst    <= edge_dst_mem[bus.edge_addr];
            bus.edge_weight <= edge_w_mem[bus.edge_addr];
        end
    end

    // Monitor and scoreboard
    always @(negedge clk) begin
        if (asyn_reset === 1'b1) begin
            if (bus.fifo_deq === 1'b1) begin
                deq_cyc.push_back(cyc);
                deq_tag.push_back(bus.fifo_tag);
            end
            if (bus.edge_rd === 1'b1) eaddr.push_back(bus.edge_addr);
            if (spike_done === 1'b1) done_cyc.push_back(cyc);
            if (bus.syn_valid === 1'b1 && bus.syn_ready === 1'b1) begin
                ev_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {bus.syn_dst, bus.syn_weight}, 32'hFFFF_FFFF);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("ev_dst", 32'(bus.syn_dst), 32'(e.dst));
                    check("ev_weight", 32'(bus.syn_weight), 32'(e.w));
                end
            end
        end
    end

    task automatic clear_logs();
        deq_cyc.delete();
        deq_tag.delete();
        ev_cyc.delete();
        done_cyc.delete();
        eaddr.delete();
    endtask

    task automatic expect_ev(input logic [TAG_W-1:0] d, input logic [WEIGHT_W-1:0] w);
        ev_t e;
        e.dst = d;
        e.w   = w;
        exp_q.push_back(e);
    endtask

    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || fifo_q.size() != 0 || bus.fifo_empty !== 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 300), 32'd1);
        repeat (2) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (bus.syn_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", 32'(bus.syn_valid), 32'd1);
    endtask

    initial begin
        asyn_reset    = 1'b0;
        bus.syn_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ptr_start_mem[i] = '0;
            ptr_count_mem[i] = '0;
        end
        for (int i = 0; i < 64; i++) begin
            edge_dst_mem[i] = '0;
            edge_w_mem[i]   = '0;
        end
        repeat (3) @(negedge clk);

        check("rst_fifo_deq", 32'(bus.fifo_deq), 32'd0);
        check("rst_ptr_rd", 32'(bus.ptr_rd), 32'd0);
        check("rst_ptr_addr", 32'(bus.ptr_addr), 32'd0);
        check("rst_edge_rd", 32'(bus.edge_rd), 32'd0);
        check("rst_edge_addr", 32'(bus.edge_addr), 32'd0);
        check("rst_syn_valid", 32'(bus.syn_valid), 32'd0);
        check("rst_syn_dst", 32'(bus.syn_dst), 32'd0);
        check("rst_syn_weight", 32'(bus.syn_weight), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_spike_done", 32'(spike_done), 32'd0);
        drive_slot();
        asyn_reset = 1'b1;

        // Basic row: tag 3 -> {10, 2}
        ptr_start_mem[3] = 6'd10;
        ptr_count_mem[3] = 4'd2;
        edge_dst_mem[10] = 4'd5;
        edge_w_mem[10]   = 8'd7;
        edge_dst_mem[11] = 4'd9;
        edge_w_mem[11]   = 8'hFE;
        clear_logs();
        drive_slot();
        bus.syn_ready = 1'b1;
        expect_ev(4'd5, 8'd7);
        expect_ev(4'd9, 8'hFE);
        fifo_q.push_back(4'd3);
        drain();
        check("t1_deq_n", 32'(deq_cyc.size()), 32'd1);
        check("t1_ev_n", 32'(ev_cyc.size()), 32'd2);
        check("t1_done_n", 32'(done_cyc.size()), 32'd1);
        if (deq_cyc.size() == 1 && ev_cyc.size() == 2 && done_cyc.size() == 1) begin
            check("t1_deq_tag", 32'(deq_tag[0]), 32'd3);
            check("t1_first_lat", 32'(ev_cyc[0] - deq_cyc[0]), 32'd4);
            check("t1_second_lat", 32'(ev_cyc[1] - deq_cyc[0]), 32'd7);
            check("t1_done_lat", 32'(done_cyc[0] - deq_cyc[0]), 32'd8);
        end
        if (eaddr.size() == 2) begin
            check("t1_eaddr0", 32'(eaddr[0]), 32'd10);
            check("t1_eaddr1", 32'(eaddr[1]), 32'd11);
        end else begin
            check("t1_eaddr_n", 32'(eaddr.size()), 32'd2);
        end

        // Empty row
        ptr_start_mem[4] = 6'd20;
        ptr_count_mem[4] = 4'd0;
        clear_logs();
        drive_slot();
        fifo_q.push_back(4'd4);
        drain();
        check("t2_deq_n", 32'(deq_cyc.size()), 32'd1);
        check("t2_ev_n", 32'(ev_cyc.size()), 32'd0);
        check("t2_edge_rd_n", 32'(eaddr.size()), 32'd0);
        check("t2_done_n", 32'(done_cyc.size()), 32'd1);
        if (deq_cyc.size() == 1 && done_cyc.size() == 1)
            check("t2_done_lat", 32'(done_cyc[0] - deq_cyc[0]), 32'd2);

        // Backpressure in OUT
        ptr_start_mem[5] = 6'd30;
        ptr_count_mem[5] = 4'd1;
        edge_dst_mem[30] = 4'd2;
        edge_w_mem[30]   = 8'h55;
        clear_logs();
        drive_slot();
        bus.syn_ready = 1'b0;
        expect_ev(4'd2, 8'h55);
        fifo_q.push_back(4'd5);
        @(negedge clk);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(bus.syn_valid), 32'd1);
            check("t3_hold_dst", 32'(bus.syn_dst), 32'd2);
            check("t3_hold_weight", 32'(bus.syn_weight), 32'h55);
            check("t3_no_edge_rd", 32'(bus.edge_rd), 32'd0);
            @(negedge clk);
        end
        drive_slot();
        bus.syn_ready = 1'b1;
        drain();
        check("t3_ev_n", 32'(ev_cyc.size()), 32'd1);
        check("t3_edge_rd_n", 32'(eaddr.size()), 32'd1);

        // Address wrap
        ptr_start_mem[6] = 6'd63;
        ptr_count_mem[6] = 4'd2;
        edge_dst_mem[63] = 4'd1;
        edge_w_mem[63]   = 8'h11;
        edge_dst_mem[0]  = 4'd12;
        edge_w_mem[0]    = 8'h22;
        clear_logs();
        drive_slot();
        expect_ev(4'd1, 8'h11);
        expect_ev(4'd12, 8'h22);
        fifo_q.push_back(4'd6);
        drain();
        if (eaddr.size() == 2) begin
            check("t4_eaddr0", 32'(eaddr[0]), 32'd63);
            check("t4_eaddr1", 32'(eaddr[1]), 32'd0);
        end else begin
            check("t4_eaddr_n", 32'(eaddr.size()), 32'd2);
        end

        // Back-to-back tags
        ptr_start_mem[7] = 6'd40;
        ptr_count_mem[7] = 4'd1;
        edge_dst_mem[40] = 4'd3;
        edge_w_mem[40]   = 8'h33;
        ptr_start_mem[8] = 6'd41;
        ptr_count_mem[8] = 4'd2;
        edge_dst_mem[41] = 4'd4;
        edge_w_mem[41]   = 8'h44;
        edge_dst_mem[42] = 4'd6;
        edge_w_mem[42]   = 8'h66;
        clear_logs();
        drive_slot();
        expect_ev(4'd3, 8'h33);
        expect_ev(4'd4, 8'h44);
        expect_ev(4'd6, 8'h66);
        fifo_q.push_back(4'd7);
        fifo_q.push_back(4'd8);
        drain();
        check("t5_deq_n", 32'(deq_cyc.size()), 32'd2);
        check("t5_done_n", 32'(done_cyc.size()), 32'd2);
        if (deq_cyc.size() == 2 && done_cyc.size() == 2) begin
            check("t5_tag0", 32'(deq_tag[0]), 32'd7);
            check("t5_tag1", 32'(deq_tag[1]), 32'd8);
            check("t5_deq_after_done", 32'(deq_cyc[1] >= done_cyc[0]), 32'd1);
        end

        // Zero-weight edge
        ptr_start_mem[9] = 6'd50;
        ptr_count_mem[9] = 4'd2;
        edge_dst_mem[50] = 4'd7;
        edge_w_mem[50]   = 8'h00;
        edge_dst_mem[51] = 4'd8;
        edge_w_mem[51]   = 8'h04;
        clear_logs();
        drive_slot();
`ifdef FIRE_DISPATCH_SKIP_ZERO_EN
        expect_ev(4'd8, 8'h04);
`else
        expect_ev(4'd7, 8'h00);
        expect_ev(4'd8, 8'h04);
`endif
        fifo_q.push_back(4'd9);
        drain();
`ifdef FIRE_DISPATCH_SKIP_ZERO_EN
        check("t6_ev_n", 32'(ev_cyc.size()), 32'd1);
`else
        check("t6_ev_n", 32'(ev_cyc.size()), 32'd2);
`endif
        check("t6_edge_rd_n", 32'(eaddr.size()), 32'd2);
        check("t6_done_n", 32'(done_cyc.size()), 32'd1);

        // Reset while presenting an event
        ptr_start_mem[10] = 6'd55;
        ptr_count_mem[10] = 4'd2;
        edge_dst_mem[55]  = 4'd9;
        edge_w_mem[55]    = 8'h19;
        clear_logs();
        drive_slot();
        bus.syn_ready = 1'b0;
        fifo_q.push_back(4'd10);
        @(negedge clk);
        wait_valid();
        #1;
        asyn_reset = 1'b0;
        #1;
        check("t7_rst_valid", 32'(bus.syn_valid), 32'd0);
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_dst", 32'(bus.syn_dst), 32'd0);
        check("t7_rst_weight", 32'(bus.syn_weight), 32'd0);
        repeat (2) @(negedge clk);
        drive_slot();
        asyn_reset    = 1'b1;
        bus.syn_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("t7_idle", 32'(busy), 32'd0);
        check("t7_no_done", 32'(done_cyc.size()), 32'd0);
        check("t7_no_ev", 32'(ev_cyc.size()), 32'd0);
        check("t7_no_redeq", 32'(deq_cyc.size()), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
